mem_port_arbiter: RTL and testbench

Single-port memory sequencer and arbiter for the multi-cycle RISC-V core. It shares one unified, fixed-latency memory between the instruction-fetch requester (IF stages) and the data requester (MEM stages). It serialises their accesses and counts out the memory latency, so the control unit waits on a ready pulse instead of hard-coding one state per latency cycle. Only one access is ever in flight.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer: serialises fetch and data accesses to a
// fixed-latency unified memory and pulses a ready to the owning requester.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned     CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                own_d_q, own_d_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_d_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_d_q     <= own_d_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  // Next-state: arbitrate in IDLE (data first), count out latency in ACCESS
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_d_d     = own_d_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          state_d     = ACCESS;
          cnt_d       = CNT_INIT;
          own_d_d     = d_req;
          we_d        = d_req & d_we;
          mem_addr_d  = d_req ? d_addr : if_addr;
          mem_wdata_d = d_wdata;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (own_d_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          d_ready_d  = own_d_q;
          if_ready_d = ~own_d_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_re    = (state_q == ACCESS) && !we_q;
  assign mem_we    = (state_q == ACCESS) && we_q && (cnt_q == '0);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LATENCY=4 and LATENCY=1 instances share stimulus
// and are compared every cycle against a cycle-index transaction model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        use_fixed;
  logic [31:0] fixed_val;

  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] if_rdata [2];
  logic [31:0] d_rdata  [2];
  logic [31:0] mem_rdata[2];
  logic        if_ready [2];
  logic        d_ready  [2];
  logic        mem_re   [2];
  logic        mem_we   [2];
  logic        busy     [2];

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int lat[2]   = '{4, 1};

  typedef struct {
    bit          valid;
    int          start;
    bit          own_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ird;
    logic [31:0] drd;
  } model_t;

  model_t m[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return use_fixed ? fixed_val : hashf(a);
  endfunction

  assign mem_rdata[0] = use_fixed ? fixed_val : hashf(mem_addr[0]);
  assign mem_rdata[1] = use_fixed ? fixed_val : hashf(mem_addr[1]);

  mem_port_arbiter #(.LATENCY(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata[0]), .d_ready(d_ready[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_re(mem_re[0]),
    .mem_we(mem_we[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata[1]), .d_ready(d_ready[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_re(mem_re[1]),
    .mem_we(mem_we[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].valid = 1'b0;
      m[i].start = 0;
      m[i].own_d = 1'b0;
      m[i].we    = 1'b0;
      m[i].addr  = '0;
      m[i].wdata = '0;
      m[i].ird   = '0;
      m[i].drd   = '0;
    end
  endtask

  // Expected outputs in cycle t follow from the accept cycle s:
  // access cycles s+1..s+L, ready in s+L+1, idle again from s+L+2.
  task automatic check_dut(input int i);
    int  s, l;
    bit  act, acc, fin;
    s   = m[i].start;
    l   = lat[i];
    act = m[i].valid && (t > s) && (t <= s + l + 1);
    acc = m[i].valid && (t > s) && (t <= s + l);
    fin = m[i].valid && (t == s + l);
    check($sformatf("busy[L%0d]", l),     32'(busy[i]),     32'(act));
    check($sformatf("mem_re[L%0d]", l),   32'(mem_re[i]),   32'(acc && !m[i].we));
    check($sformatf("mem_we[L%0d]", l),   32'(mem_we[i]),   32'(fin && m[i].we));
    check($sformatf("if_ready[L%0d]", l), 32'(if_ready[i]), 32'(m[i].valid && !m[i].own_d && t == s + l + 1));
    check($sformatf("d_ready[L%0d]", l),  32'(d_ready[i]),  32'(m[i].valid && m[i].own_d && t == s + l + 1));
    check($sformatf("if_rdata[L%0d]", l), if_rdata[i], m[i].ird);
    check($sformatf("d_rdata[L%0d]", l),  d_rdata[i],  m[i].drd);
    check($sformatf("mem_addr[L%0d]", l), mem_addr[i], m[i].addr);
    if (fin && m[i].we) check($sformatf("mem_wdata[L%0d]", l), mem_wdata[i], m[i].wdata);
  endtask

  task automatic advance(input int i);
    int s, l;
    s = m[i].start;
    l = lat[i];
    if (!reset_n) return;
    if (m[i].valid && !m[i].we && t == s + l) begin
      if (m[i].own_d) m[i].drd = mem_model(m[i].addr);
      else            m[i].ird = mem_model(m[i].addr);
    end
    if ((!m[i].valid || t >= s + l + 2) && (d_req || if_req)) begin
      m[i].valid = 1'b1;
      m[i].start = t;
      m[i].own_d = d_req;
      m[i].we    = d_req && d_we;
      m[i].addr  = d_req ? d_addr : if_addr;
      m[i].wdata = d_wdata;
    end
  endtask

  // One cycle: check current outputs, then drive this cycle's inputs.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    t++;
    check_dut(0);
    check_dut(1);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    advance(0);
    advance(1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_busy"},  32'(busy[i]),     0);
      check({tag, "_re"},    32'(mem_re[i]),   0);
      check({tag, "_we"},    32'(mem_we[i]),   0);
      check({tag, "_irdy"},  32'(if_ready[i]), 0);
      check({tag, "_drdy"},  32'(d_ready[i]),  0);
      check({tag, "_addr"},  mem_addr[i],      0);
      check({tag, "_wdata"}, mem_wdata[i],     0);
      check({tag, "_ird"},   if_rdata[i],      0);
      check({tag, "_drd"},   d_rdata[i],       0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    if_addr   = '0;
    d_addr    = '0;
    d_wdata   = '0;
    use_fixed = 1'b1;
    fixed_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fetch from 0x10 returning 0x00A00093
    fixed_val = 32'h00A0_0093;
    step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    idle(7);
    check("fetch_ird", if_rdata[0], 32'h00A0_0093);
    check("fetch_drd", d_rdata[0], 32'h0);

    // Store 0xDEADBEEF to 0x100
    step(1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    idle(7);

    // Collision: load 0x200 -> 5 beats a fetch held high
    fixed_val = 32'h5;
    step(1'b1, 32'h40, 1'b1, 1'b0, 32'h200, '0);
    for (int k = 0; k < 11; k++) step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
    idle(7);
    check("coll_drd", d_rdata[0], 32'h5);

    // Load whose inputs change and whose request drops mid-access
    fixed_val = 32'h1234_5678;
    step(1'b0, '0, 1'b1, 1'b0, 32'h300, '0);
    step(1'b0, '0, 1'b1, 1'b0, 32'h300, '0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h3FC, 32'hFFFF_FFFF);
    idle(7);

    // Reset during cycle 2 of a store
    step(1'b0, '0, 1'b1, 1'b1, 32'h500, 32'hCAFE_F00D);
    idle(1);
    @(negedge clk);
    t++;
    check_dut(0);
    check_dut(1);
    if_req  = 1'b0;
    d_req   = 1'b0;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    idle(3);
    reset_n = 1'b1;
    fixed_val = 32'h0000_0013;
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
    idle(7);
    check("postrst_ird4", if_rdata[0], 32'h13);
    check("postrst_ird1", if_rdata[1], 32'h13);

    // Randomised traffic
    use_fixed = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 40), $urandom, ($urandom_range(0, 99) < 35),
           $urandom_range(0, 1) == 1, $urandom, $urandom);
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
